// File: rtl/crc_port_arbiter_if.sv
// crc_port_arbiter_if: handshake bundle between ingress ports, the port arbiter and the CRC checker
//   master: arbiter side (drives gnt, chk_*, res_*, busy)
//   slave : environment side (drives pkt_req, in_*, crc_valid)
interface crc_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  logic [NUM_PORTS-1:0]            pkt_req;
  logic [NUM_PORTS-1:0]            gnt;
  logic [NUM_PORTS-1:0]            in_sop;
  logic [NUM_PORTS-1:0]            in_eop;
  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic                            chk_sop;
  logic                            chk_eop;
  logic                            chk_valid;
  logic [DATA_WIDTH-1:0]           chk_data;
  logic                            crc_valid;
  logic                            res_valid;
  logic [PW-1:0]                   res_port;
  logic                            res_pass;
  logic                            res_err;
  logic                            busy;
  modport master (
    input  pkt_req, in_sop, in_eop, in_valid, in_data, crc_valid,
    output gnt, chk_sop, chk_eop, chk_valid, chk_data, res_valid, res_port, res_pass, res_err, busy
  );
  modport slave (
    output pkt_req, in_sop, in_eop, in_valid, in_data, crc_valid,
    input  gnt, chk_sop, chk_eop, chk_valid, chk_data, res_valid, res_port, res_pass, res_err, busy
  );
endinterface

// File: rtl/crc_port_arbiter.sv
// crc_port_arbiter: round-robin, packet-granular sharing of one CRC-8 checker among NUM_PORTS ingress ports
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : pkt_req/in_* from ports, gnt back to ports, chk_* to checker, crc_valid from checker,
//              res_* per-packet verdict, busy when not idle
module crc_port_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_LEN     = 128,
  parameter int RES_TIMEOUT = 4
) (
  input logic               clk,
  input logic               rst,
  crc_port_arbiter_if.master bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(RES_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, XFER, WAIT_RES, REPORT} state_t;
  state_t                r_state, w_next;
  logic [PW-1:0]         r_ptr, r_idx, w_sel, w_cand;
  logic [CW-1:0]         r_cnt;
  logic [TW-1:0]         r_wcnt;
  logic                  r_pass, r_err, r_sop, r_eop, r_valid;
  logic [DATA_WIDTH-1:0] r_data, w_gd;
  logic                  w_xfer, w_rep, w_over, w_done, w_gv, w_gs, w_ge;
  assign w_xfer = r_state == XFER;
  assign w_rep  = r_state == REPORT;
  assign w_over = r_cnt == CW'(MAX_LEN);
  assign w_done = r_wcnt == TW'(RES_TIMEOUT - 1);
  assign w_gv   = bus.in_valid[r_idx];
  assign w_gs   = bus.in_sop[r_idx];
  assign w_ge   = bus.in_eop[r_idx];
  assign w_gd   = bus.in_data[r_idx*DATA_WIDTH +: DATA_WIDTH];
  // Scan downward so the lowest offset above the pointer wins.
  always_comb begin
    w_sel  = r_ptr;
    w_cand = r_ptr;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_cand = PW'((int'(r_ptr) + k) % NUM_PORTS);
      if (bus.pkt_req[w_cand]) w_sel = w_cand;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = |bus.pkt_req ? XFER : IDLE;
      XFER:     w_next = w_over ? REPORT : (w_gv && w_ge) ? WAIT_RES : XFER;
      WAIT_RES: w_next = (bus.crc_valid || w_done) ? REPORT : WAIT_RES;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= PW'(NUM_PORTS - 1);
      r_idx   <= '0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_pass  <= 1'b0;
      r_err   <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      // Once MAX_LEN beats are in, the stream is cut: a lone eop closes the checker's packet.
      r_valid <= w_xfer && !w_over && w_gv;
      r_sop   <= w_xfer && !w_over && w_gs;
      r_eop   <= w_xfer && (w_over || w_ge);
      r_data  <= (w_xfer && !w_over) ? w_gd : '0;
      unique case (r_state)
        IDLE: begin
          r_idx  <= w_sel;
          r_cnt  <= '0;
          r_wcnt <= '0;
          r_pass <= 1'b0;
          r_err  <= 1'b0;
        end
        XFER: begin
          if (w_over)    r_err <= 1'b1;
          else if (w_gv) r_cnt <= r_cnt + 1'b1;
        end
        WAIT_RES: begin
          r_wcnt <= r_wcnt + 1'b1;
          if (bus.crc_valid) r_pass <= 1'b1;
        end
        default: r_ptr <= r_idx;
      endcase
    end
  end
  assign bus.gnt       = w_xfer ? (NUM_PORTS'(1) << r_idx) : '0;
  assign bus.chk_sop   = r_sop;
  assign bus.chk_eop   = r_eop;
  assign bus.chk_valid = r_valid;
  assign bus.chk_data  = r_data;
  assign bus.res_valid = w_rep;
  assign bus.res_port  = w_rep ? r_idx : '0;
  assign bus.res_pass  = w_rep && r_pass;
  assign bus.res_err   = w_rep && r_err;
  assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_crc_port_arbiter.sv
// tb_crc_port_arbiter: randomized and directed checks of crc_port_arbiter against a packet-level model
module tb_crc_port_arbiter;
  localparam int NP = 4, DW = 8, ML = 128, RT = 4;
  typedef struct {logic [7:0] d; bit sop; bit eop; int dly;} beat_t;
  typedef struct {bit over; int dly;} pkt_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  crc_port_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();
  crc_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_LEN(ML), .RES_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int total = 0, bad = 0;
  beat_t pq[NP][$];
  pkt_t  pd[NP][$];
  int gq[$], expg[$], expv[$];
  logic [31:0] rq[$];
  bit drv_v[NP];
  int gcnt[NP];
  int gap, bc, pbc, cyc, eop_cyc, cur_dly, pend_dly, cd, mptr;
  bit pg, forced, prev_any;
  logic [2:0] pvec_ctl;
  logic [7:0] pvec_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int oi(input logic [NP-1:0] g);
    for (int p = 0; p < NP; p++) if (g[p]) return p;
    return -1;
  endfunction

  task automatic clear_bench();
    for (int p = 0; p < NP; p++) begin
      pq[p].delete();
      pd[p].delete();
      drv_v[p] = 0;
      gcnt[p] = 0;
    end
    bus.pkt_req = '0; bus.in_sop = '0; bus.in_eop = '0; bus.in_valid = '0; bus.in_data = '0;
    bus.crc_valid = 1'b0;
    bc = 0; pbc = 0; pg = 0; forced = 0; cd = 0; cur_dly = -1; pend_dly = -1; eop_cyc = 0; prev_any = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_bench();
    mptr = NP - 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add_pkt(input int p, input int len, input bit has_eop, input int dly);
    beat_t b;
    pkt_t k;
    for (int i = 0; i < len; i++) begin
      b.d = 8'($urandom);
      b.sop = (i == 0);
      b.eop = has_eop && (i == len - 1);
      b.dly = dly;
      pq[p].push_back(b);
    end
    k.over = !has_eop || len > ML;
    k.dly = dly;
    pd[p].push_back(k);
  endtask

  task automatic step();
    logic [NP-1:0] g;
    bit e;
    beat_t b;
    @(negedge clk);
    cyc++;
    g = bus.gnt;
    e = 0;
    for (int p = 0; p < NP; p++) if (drv_v[p]) begin
      b = pq[p].pop_front();
      drv_v[p] = 0;
      if (b.eop) pend_dly = b.dly;
      else gcnt[p] = gap;
    end
    if (pg) begin
      if (pbc >= ML) begin
        chk("forced_eop", {bus.chk_eop, bus.chk_valid}, 2'b10);
        forced = 1;
        eop_cyc = cyc;
      end else begin
        chk("chk_ctl", {bus.chk_valid, bus.chk_sop, bus.chk_eop}, pvec_ctl);
        if (pvec_ctl[2]) chk("chk_data", bus.chk_data, pvec_d);
      end
    end else chk("chk_idle", bus.chk_valid, 0);
    if (bus.chk_valid === 1'b1 && bus.chk_eop === 1'b1) begin
      eop_cyc = cyc;
      forced = 0;
      cur_dly = pend_dly;
      e = 1;
    end
    chk("gnt_onehot0", $onehot0(g), 1);
    if (g != 0 && !prev_any) begin
      gq.push_back(oi(g));
      bc = 0;
      for (int p = 0; p < NP; p++) gcnt[p] = 0;
    end
    prev_any = (g != 0);
    if (bus.res_valid) begin
      rq.push_back({27'd0, bus.res_port, bus.res_pass, bus.res_err});
      chk("res_timing", cyc - eop_cyc, forced ? 0 : (cur_dly >= 0 && cur_dly < RT) ? cur_dly + 1 : RT);
    end
    bus.crc_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) bus.crc_valid = 1'b1;
    end
    if (e) begin
      if (cur_dly == 0) bus.crc_valid = 1'b1;
      else if (cur_dly > 0) cd = cur_dly;
    end
    pg = (g != 0);
    pbc = bc;
    pvec_ctl = '0;
    pvec_d = '0;
    for (int p = 0; p < NP; p++) begin
      if (!g[p]) while (pq[p].size() > 0 && !pq[p][0].sop) void'(pq[p].pop_front());
      bus.pkt_req[p] = pq[p].size() > 0;
      bus.in_data[p*DW +: DW] = 8'($urandom);
      if (g[p]) begin
        bus.in_valid[p] = 0; bus.in_sop[p] = 0; bus.in_eop[p] = 0;
        if (pq[p].size() > 0) begin
          if (gcnt[p] > 0) gcnt[p]--;
          else begin
            bus.in_valid[p] = 1;
            bus.in_sop[p] = pq[p][0].sop;
            bus.in_eop[p] = pq[p][0].eop;
            bus.in_data[p*DW +: DW] = pq[p][0].d;
            drv_v[p] = 1;
            bc++;
          end
        end
        pvec_ctl = {bus.in_valid[p], bus.in_sop[p], bus.in_eop[p]};
        pvec_d = bus.in_data[p*DW +: DW];
      end else begin
        bus.in_valid[p] = 1'($urandom);
        bus.in_sop[p] = 1'($urandom);
        bus.in_eop[p] = 1'($urandom);
      end
    end
  endtask

  function automatic bit bench_idle();
    for (int p = 0; p < NP; p++) if (pq[p].size() > 0 || drv_v[p]) return 0;
    return bus.busy === 1'b0 && cd == 0;
  endfunction

  task automatic run(input int budget);
    int idx[NP];
    int n, f, q;
    bit ps;
    expg.delete(); expv.delete(); gq.delete(); rq.delete();
    for (int p = 0; p < NP; p++) idx[p] = 0;
    while (1) begin
      f = -1;
      for (int k = 1; k <= NP; k++) begin
        q = (mptr + k) % NP;
        if (f < 0 && idx[q] < pd[q].size()) f = q;
      end
      if (f < 0) break;
      ps = !pd[f][idx[f]].over && pd[f][idx[f]].dly >= 0 && pd[f][idx[f]].dly < RT;
      expg.push_back(f);
      expv.push_back(f * 4 + (ps ? 2 : 0) + (pd[f][idx[f]].over ? 1 : 0));
      mptr = f;
      idx[f]++;
    end
    for (int p = 0; p < NP; p++) pd[p].delete();
    n = 0;
    while (n < budget && !bench_idle()) begin
      step();
      n++;
    end
    chk("run_budget", n < budget, 1);
    chk("grant_count", gq.size(), expg.size());
    for (int i = 0; i < gq.size() && i < expg.size(); i++) chk("grant_order", gq[i], expg[i]);
    chk("verdict_count", rq.size(), expv.size());
    for (int i = 0; i < rq.size() && i < expv.size(); i++) chk("verdict", rq[i], expv[i]);
  endtask

  initial begin
    int n;
    cyc = 0;
    gap = 0;
    do_reset();
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res", {bus.res_valid, bus.res_pass, bus.res_err, bus.res_port}, 0);
    chk("rst_chk", {bus.chk_valid, bus.chk_sop, bus.chk_eop, bus.chk_data}, 0);
    // single port 1 packet, pass one cycle after eop
    add_pkt(1, 4, 1, 1);
    pq[1][0].d = 8'h01; pq[1][1].d = 8'h02; pq[1][2].d = 8'h03; pq[1][3].d = 8'hA5;
    run(100);
    // all ports requesting from reset: 0,1,2,3,0,1,2,3
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) add_pkt(p, $urandom_range(2, 6), 1, $urandom_range(0, 3));
    run(500);
    chk("rr_first", gq.size() > 0 ? gq[0] : -1, 0);
    // checker never answers
    add_pkt(2, 3, 1, -1);
    run(100);
    // overlength, then another requester
    add_pkt(0, 130, 0, 0);
    add_pkt(1, 3, 1, 2);
    run(500);
    // exactly MAX_LEN beats is legal
    add_pkt(3, ML, 1, 0);
    run(400);
    // stalls inside a packet
    gap = 3;
    add_pkt(3, 5, 1, 1);
    add_pkt(0, 4, 1, 3);
    run(200);
    // random traffic
    for (int r = 0; r < 8; r++) begin
      gap = $urandom_range(0, 2);
      for (int p = 0; p < NP; p++)
        repeat ($urandom_range(0, 2)) add_pkt(p, $urandom_range(1, 10), 1, int'($urandom_range(0, 6)) - 1);
      run(2000);
    end
    gap = 0;
    // reset mid-transfer on port 2
    add_pkt(2, 20, 1, 1);
    pd[2].delete();
    n = 0;
    while (n < 100 && !(bus.gnt[2] === 1'b1 && bc >= 5)) begin
      step();
      n++;
    end
    chk("mid_xfer_reached", bus.gnt[2], 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_gnt", bus.gnt, 0);
    chk("mid_rst_res", bus.res_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    do_reset();
    for (int p = 0; p < NP; p++) add_pkt(p, 3, 1, 1);
    run(300);
    chk("post_rst_first", gq.size() > 0 ? gq[0] : -1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
